// File: rtl/lab4_branch_branch_gshare.sv
// Gshare/bimodal branch direction predictor: PHT of saturating counters plus a global history register.
// Latency: prediction is combinational (zero cycles); updates commit on the next posedge of clk.
// Backpressure: none; one update may be accepted every cycle and is never stalled.
//
// Ports:
//   clk         sole clock, all state changes on posedge
//   reset       synchronous, active-high; clears every counter and the history
//   update_en   commit one resolved outcome at the next posedge
//   update_val  resolved outcome (1 = taken)
//   PC          branch address, shared by lookup and update in the same cycle
//   prediction  MSB of the indexed counter (1 = predict taken)
//   ghr         global history, bit 0 is the most recent outcome
//
// Build option: define LAB4_BRANCH_GSHARE_HASH_EN to XOR the history into the
// PHT index (gshare). Without it the index is the PC alone (bimodal), but the
// history register is still maintained and driven out.
//
// Parameter ranges: p_num_entries a power of two >= 4, p_ctr_bits 1..4,
// p_hist_bits 1..log2(p_num_entries).

module lab4_branch_branch_gshare #(
  parameter int p_num_entries = 1024,
  parameter int p_ctr_bits    = 2,
  parameter int p_hist_bits   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   update_en,
  input  logic                   update_val,
  input  logic [31:0]            PC,
  output logic                   prediction,
  output logic [p_hist_bits-1:0] ghr
);

  localparam int IDX_W = $clog2(p_num_entries);
  localparam logic [p_ctr_bits-1:0] CTR_MAX  = '1;
  localparam logic [p_ctr_bits-1:0] CTR_ZERO = '0;
  localparam logic [p_ctr_bits-1:0] CTR_ONE  = p_ctr_bits'(1);

  logic [p_ctr_bits-1:0]  pht [p_num_entries];
  logic [IDX_W-1:0]       base_idx;
  logic [IDX_W-1:0]       idx;
  logic [p_ctr_bits-1:0]  cur_ctr;
  logic [p_ctr_bits-1:0]  nxt_ctr;
  logic [p_hist_bits-1:0] ghr_nxt;

  // Word-aligned PC: the two byte-offset bits and the bits above the index
  // carry no predictor information.
  assign base_idx = PC[IDX_W+1:2];

  logic unused_pc;
  assign unused_pc = ^{PC[31:IDX_W+2], PC[1:0]};

`ifdef LAB4_BRANCH_GSHARE_HASH_EN
  logic [IDX_W-1:0] ghr_ext;

  // History is shorter than (or equal to) the index; zero-extend before XOR.
  always_comb begin
    ghr_ext = '0;
    ghr_ext[p_hist_bits-1:0] = ghr;
  end

  assign idx = base_idx ^ ghr_ext;
`else
  assign idx = base_idx;
`endif

  // Lookup and update share one index, computed from the pre-edge history,
  // so the counter written is exactly the one that produced the prediction.
  assign cur_ctr    = pht[idx];
  assign prediction = cur_ctr[p_ctr_bits-1];

  // Saturating step: hold at the rails instead of wrapping.
  always_comb begin
    nxt_ctr = cur_ctr;
    if (update_val) begin
      if (cur_ctr != CTR_MAX) nxt_ctr = cur_ctr + CTR_ONE;
    end else begin
      if (cur_ctr != CTR_ZERO) nxt_ctr = cur_ctr - CTR_ONE;
    end
  end

  // Shift then overwrite bit 0; written this way it also works for a
  // one-bit history, where the whole register is just the last outcome.
  always_comb begin
    ghr_nxt    = ghr << 1;
    ghr_nxt[0] = update_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < p_num_entries; i++) begin
        pht[i] <= '0;
      end
      ghr <= '0;
    end else if (update_en) begin
      pht[idx] <= nxt_ctr;
      ghr      <= ghr_nxt;
    end
  end

endmodule

// File: doc/lab4_branch_branch_gshare.md
LAB4_BRANCH_BRANCH_GSHARE -- requirements
Module: lab4_branch_branch_gshare

Interface
REQ-001 The block SHALL have parameter p_num_entries, default 1024, giving the PHT depth; it SHALL be a power of two, at least 4.
REQ-002 The block SHALL have parameter p_ctr_bits, default 2, giving the saturating counter width; valid range is 1 to 4.
REQ-003 The block SHALL have parameter p_hist_bits, default 8, giving the GHR length; valid range is 1 to log2(p_num_entries).
REQ-004 clk  input  1  sole clock; all state updates on its posedge.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 update_en  input  1  commits one resolved branch outcome at the next posedge.
REQ-007 update_val  input  1  resolved outcome: 1 = taken, 0 = not taken.
REQ-008 PC  input  32  branch address, used for both lookup and update in the same cycle.
REQ-009 prediction  output  1  predicted direction for PC: 1 = taken.
REQ-010 ghr  output  p_hist_bits  current global history register; bit 0 is the most recent outcome.

Function
REQ-011 The index width SHALL be idx = log2(p_num_entries), with base index = PC[idx+1:2]; PC[1:0] are ignored.
REQ-012 When history hashing is enabled, index SHALL be base index XOR the zero-extended ghr.
REQ-013 prediction SHALL be combinational and equal to the MSB of PHT[index], using the current-cycle PC and ghr with zero-cycle latency.
REQ-014 On a posedge with update_en=1 and reset=0, PHT[index] SHALL increment if update_val=1 and decrement if update_val=0.
REQ-015 Counters SHALL saturate: they SHALL hold at 2^p_ctr_bits-1 on a taken update and at 0 on a not-taken update; there is no wrap-around.
REQ-016 On the same edge, ghr SHALL shift left by one with update_val entering bit 0; the oldest bit is discarded.
REQ-017 The update SHALL use the index computed from the pre-edge ghr; prediction after the edge reflects both the new counter and the new ghr.
REQ-018 When update_en=0, no PHT entry and no ghr bit SHALL change.
REQ-019 Exactly one PHT entry SHALL be written per update; all other entries SHALL be unchanged.

Reset
REQ-020 While reset=1 at a posedge, all PHT counters SHALL become 0 and ghr SHALL become 0, regardless of update_en.
REQ-021 After reset, prediction SHALL be 0 for every PC.
REQ-022 Reset asserted mid-sequence SHALL discard any concurrent update; no partial state is retained.

Configuration
REQ-023 Macro LAB4_BRANCH_GSHARE_HASH_EN SHALL select the indexing mode.
  - Defined: index is base XOR ghr (gshare).
  - Undefined: index is base only (bimodal indexing), while ghr is still maintained and output.
  - All other behaviour SHALL be identical in both modes.

Verification (p_num_entries=1024, p_ctr_bits=2, p_hist_bits=4)
REQ-024 Reset check: reset one cycle, then PC=0x20C (base index 131) -> prediction=0, ghr=0, PHT[131]=00.
REQ-025 Macro undefined, taken sequence at PC=0x20C:
  - 4 taken updates -> PHT[131] goes 01, 10, 11, 11; prediction goes 0, 1, 1, 1.
  - Then 4 not-taken updates -> 10, 01, 00, 00.
REQ-026 Macro defined, from reset, 2 taken updates at PC=0x20C:
  - Expect PHT[131]=01, then PHT[130]=01, with ghr=0011.
  - Then the lookup at PC=0x20C indexes 128 -> prediction=0.
REQ-027 History shift: 5 taken updates from reset -> ghr goes 0001, 0011, 0111, 1111, 1111; one not-taken update -> 1110.
REQ-028 Reset priority: reset=1 with update_en=1, update_val=1 for one edge -> PHT[131]=00, ghr=0000.
REQ-029 Isolation: updates at PC=0x20C -> entries other than the written index remain 00; a lookup at PC=0x210 (base index 132, macro undefined) predicts 0.
